intr_ctx_sequencer: RTL and testbench

//  Companion sequencer to the PC unit. Generates the project-reset and interrupt strobes the PC unit consumes.

---
 rtl/intr_ctx_sequencer_if.sv | 21 ++
 rtl/intr_ctx_sequencer.sv | 175 +++++++++++++++++
 tb/tb_intr_ctx_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/intr_ctx_sequencer_if.sv
// Memory port owned by the interrupt/context sequencer while it stalls the pipeline.
// The sequencer drives address/strobes; the memory returns read data in the same cycle.
interface intr_ctx_sequencer_if #(
  parameter int AW = 8
);
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] mem_wdata;
  logic [AW-1:0] mem_rdata;

  modport master (
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/intr_ctx_sequencer.sv
// Reset/interrupt/RTI sequencer: loads the vectors, pushes PC and flags onto the stack,
// and pops them back on RTI, stalling fetch/decode whenever it owns memory.
module intr_ctx_sequencer #(
  parameter int AW           = 8,
  parameter int FLAG_W       = 4,
  parameter int RST_VEC_ADDR = 0,
  parameter int INT_VEC_ADDR = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ext_rst_req,
  input  logic                  i_intr_req,
  input  logic                  i_instr_boundary,
  input  logic                  i_rti_req,
  input  logic [AW-1:0]         i_pc_in,
  input  logic [FLAG_W-1:0]     i_flags_in,
  input  logic [AW-1:0]         i_sp_in,
  output logic                  o_sp_wr_en,
  output logic [AW-1:0]         o_sp_wr_data,
  intr_ctx_sequencer_if.master  bus,
  output logic                  o_project_rst_out,
  output logic                  o_intr_out,
  output logic                  o_intr_ack,
  output logic                  o_ret_valid,
  output logic [AW-1:0]         o_ret_addr,
  output logic                  o_flags_rest_en,
  output logic [FLAG_W-1:0]     o_flags_rest,
  output logic                  o_stall
);

  typedef enum logic [2:0] {
    S_RSTV,
    S_IDLE,
    S_PUSH_PC,
    S_PUSH_FL,
    S_INTV,
    S_POP_FL,
    S_POP_PC
  } state_t;

  localparam logic [AW-1:0] L_RST_VEC = AW'(RST_VEC_ADDR);
  localparam logic [AW-1:0] L_INT_VEC = AW'(INT_VEC_ADDR);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_sp_w;
  logic [AW-1:0]     r_saved_pc;
  logic [FLAG_W-1:0] r_saved_fl;
  logic [AW-1:0]     w_sp_dec;
  logic [AW-1:0]     w_sp_inc;
  logic              w_take_rti;
  logic              w_take_intr;

  // Stack pointer arithmetic wraps modulo 2^AW by construction.
  assign w_sp_dec    = r_sp_w - 1'b1;
  assign w_sp_inc    = r_sp_w + 1'b1;
  assign w_take_rti  = (r_state == S_IDLE) && !i_ext_rst_req && i_rti_req;
  assign w_take_intr = (r_state == S_IDLE) && !i_ext_rst_req && !i_rti_req &&
                       i_intr_req && i_instr_boundary;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RSTV;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp_w     <= '0;
      r_saved_pc <= '0;
      r_saved_fl <= '0;
    end else begin
      if (w_take_rti) begin
        r_sp_w <= i_sp_in;
      end else if (w_take_intr) begin
        r_sp_w     <= i_sp_in;
        r_saved_pc <= i_pc_in;
        r_saved_fl <= i_flags_in;
      end else begin
        case (r_state)
          S_PUSH_PC, S_PUSH_FL: r_sp_w <= w_sp_dec;
          S_POP_FL, S_POP_PC:   r_sp_w <= w_sp_inc;
          default:              r_sp_w <= r_sp_w;
        endcase
      end
    end
  end

  // External reset preempts every state, including a half-finished push or pop.
  always_comb begin
    w_state_nxt = r_state;
    if (i_ext_rst_req) begin
      w_state_nxt = S_RSTV;
    end else begin
      case (r_state)
        S_RSTV:    w_state_nxt = S_IDLE;
        S_IDLE: begin
          if (w_take_rti)       w_state_nxt = S_POP_FL;
          else if (w_take_intr) w_state_nxt = S_PUSH_PC;
        end
        S_PUSH_PC: w_state_nxt = S_PUSH_FL;
        S_PUSH_FL: w_state_nxt = S_INTV;
        S_INTV:    w_state_nxt = S_IDLE;
        S_POP_FL:  w_state_nxt = S_POP_PC;
        S_POP_PC:  w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_RSTV;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    o_sp_wr_en        = 1'b0;
    o_sp_wr_data      = '0;
    bus.mem_en        = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    o_project_rst_out = 1'b0;
    o_intr_out        = 1'b0;
    o_intr_ack        = 1'b0;
    o_ret_valid       = 1'b0;
    o_ret_addr        = '0;
    o_flags_rest_en   = 1'b0;
    o_flags_rest      = '0;
    o_stall           = (r_state != S_IDLE);
    case (r_state)
      S_RSTV: begin
        bus.mem_en        = 1'b1;
        bus.mem_addr      = L_RST_VEC;
        o_project_rst_out = 1'b1;
      end
      S_PUSH_PC: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = r_sp_w;
        bus.mem_wdata = r_saved_pc;
        o_sp_wr_en    = 1'b1;
        o_sp_wr_data  = w_sp_dec;
      end
      S_PUSH_FL: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = r_sp_w;
        bus.mem_wdata = AW'(r_saved_fl);
        o_sp_wr_en    = 1'b1;
        o_sp_wr_data  = w_sp_dec;
      end
      S_INTV: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = L_INT_VEC;
        o_intr_out   = 1'b1;
        o_intr_ack   = 1'b1;
      end
      S_POP_FL: begin
        bus.mem_en      = 1'b1;
        bus.mem_addr    = w_sp_inc;
        o_flags_rest    = bus.mem_rdata[FLAG_W-1:0];
        o_flags_rest_en = 1'b1;
        o_sp_wr_en      = 1'b1;
        o_sp_wr_data    = w_sp_inc;
      end
      S_POP_PC: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = w_sp_inc;
        o_ret_addr   = bus.mem_rdata;
        o_ret_valid  = 1'b1;
        o_sp_wr_en   = 1'b1;
        o_sp_wr_data = w_sp_inc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intr_ctx_sequencer.sv
// Directed bench for intr_ctx_sequencer: a per-cycle vector table plus hand-written
// sequences for latency and asynchronous reset, against a small memory model.
module tb_intr_ctx_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ext_rst_req = 1'b0;
  logic       intr_req = 1'b0;
  logic       instr_boundary = 1'b0;
  logic       rti_req = 1'b0;
  logic [7:0] pc_in = '0;
  logic [3:0] flags_in = '0;
  logic [7:0] sp_in = '0;
  logic       sp_wr_en;
  logic [7:0] sp_wr_data;
  logic       project_rst_out;
  logic       intr_out;
  logic       intr_ack;
  logic       ret_valid;
  logic [7:0] ret_addr;
  logic       flags_rest_en;
  logic [3:0] flags_rest;
  logic       stall;

  int tests_run = 0;
  int tests_failed = 0;

  intr_ctx_sequencer_if #(.AW(8)) bus ();

  intr_ctx_sequencer #(
    .AW(8), .FLAG_W(4), .RST_VEC_ADDR(0), .INT_VEC_ADDR(1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_ext_rst_req     (ext_rst_req),
    .i_intr_req        (intr_req),
    .i_instr_boundary  (instr_boundary),
    .i_rti_req         (rti_req),
    .i_pc_in           (pc_in),
    .i_flags_in        (flags_in),
    .i_sp_in           (sp_in),
    .o_sp_wr_en        (sp_wr_en),
    .o_sp_wr_data      (sp_wr_data),
    .bus               (bus),
    .o_project_rst_out (project_rst_out),
    .o_intr_out        (intr_out),
    .o_intr_ack        (intr_ack),
    .o_ret_valid       (ret_valid),
    .o_ret_addr        (ret_addr),
    .o_flags_rest_en   (flags_rest_en),
    .o_flags_rest      (flags_rest),
    .o_stall           (stall)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge, preloaded during rst.
  logic [7:0] mem [256];
  always_comb bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[0] <= 8'h20;
      mem[1] <= 8'h80;
    end else if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  // ctrl bit order: stall, mem_en, mem_we, sp_wr_en, project_rst, intr_out, intr_ack, ret_valid, flags_rest_en
  typedef struct {
    logic       ext, intr, bnd, rti;
    logic [7:0] pc;
    logic [3:0] fl;
    logic [7:0] sp;
    logic [8:0] ctrl;
    logic [7:0] addr, wdata, spd, ret;
    logic [3:0] flr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ext, intr, bnd, rti, input logic [7:0] pc,
                              input logic [3:0] fl, input logic [7:0] sp, input logic [8:0] ctrl,
                              input logic [7:0] addr, wdata, spd, ret, input logic [3:0] flr);
    vec_t v;
    v.ext = ext; v.intr = intr; v.bnd = bnd; v.rti = rti;
    v.pc = pc; v.fl = fl; v.sp = sp; v.ctrl = ctrl;
    v.addr = addr; v.wdata = wdata; v.spd = spd; v.ret = ret; v.flr = flr;
    return v;
  endfunction

  function automatic logic [8:0] ctrl_now();
    return {stall, bus.mem_en, bus.mem_we, sp_wr_en, project_rst_out,
            intr_out, intr_ack, ret_valid, flags_rest_en};
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive(input vec_t v);
    ext_rst_req    = v.ext;
    intr_req       = v.intr;
    instr_boundary = v.bnd;
    rti_req        = v.rti;
    pc_in          = v.pc;
    flags_in       = v.fl;
    sp_in          = v.sp;
  endtask

  initial begin
    int stall_cnt;
    bit seen;

    // RSTV after reset
    vecs.push_back(mk(0,0,0,0,8'h00,4'h0,8'hFF, 9'b110010000, 8'h00,8'h00,8'h00,8'h00,4'h0));
    vecs.push_back(mk(0,0,0,0,8'h00,4'h0,8'hFF, 9'b000000000, 8'h00,8'h00,8'h00,8'h00,4'h0));
    // Interrupt from SP=FF; rti pulse during PUSH_FL must be dropped
    vecs.push_back(mk(0,1,1,0,8'h34,4'hA,8'hFF, 9'b000000000, 8'h00,8'h00,8'h00,8'h00,4'h0));
    vecs.push_back(mk(0,1,0,0,8'h99,4'h0,8'hFF, 9'b111100000, 8'hFF,8'h34,8'hFE,8'h00,4'h0));
    vecs.push_back(mk(0,1,0,1,8'h99,4'h0,8'hFE, 9'b111100000, 8'hFE,8'h0A,8'hFD,8'h00,4'h0));
    vecs.push_back(mk(0,1,0,0,8'h99,4'h0,8'hFD, 9'b110001100, 8'h01,8'h00,8'h00,8'h00,4'h0));
    vecs.push_back(mk(0,0,0,0,8'h99,4'h0,8'hFD, 9'b000000000, 8'h00,8'h00,8'h00,8'h00,4'h0));
    // RTI from SP=FD
    vecs.push_back(mk(0,0,0,1,8'h99,4'h0,8'hFD, 9'b000000000, 8'h00,8'h00,8'h00,8'h00,4'h0));
    vecs.push_back(mk(0,0,0,0,8'h99,4'h0,8'hFD, 9'b110100001, 8'hFE,8'h00,8'hFE,8'h00,4'hA));
    vecs.push_back(mk(0,0,0,0,8'h99,4'h0,8'hFE, 9'b110100010, 8'hFF,8'h00,8'hFF,8'h34,4'h0));
    vecs.push_back(mk(0,0,0,0,8'h99,4'h0,8'hFF, 9'b000000000, 8'h00,8'h00,8'h00,8'h00,4'h0));
    // Simultaneous rti and intr: RTI first (pops across FF->00 wrap), interrupt at a later boundary
    vecs.push_back(mk(0,1,1,1,8'h56,4'h5,8'hFF, 9'b000000000, 8'h00,8'h00,8'h00,8'h00,4'h0));
    vecs.push_back(mk(0,1,1,0,8'h56,4'h5,8'hFF, 9'b110100001, 8'h00,8'h00,8'h00,8'h00,4'h0));
    vecs.push_back(mk(0,1,1,0,8'h56,4'h5,8'h00, 9'b110100010, 8'h01,8'h00,8'h01,8'h80,4'h0));
    vecs.push_back(mk(0,1,0,0,8'h56,4'h5,8'h40, 9'b000000000, 8'h00,8'h00,8'h00,8'h00,4'h0));
    vecs.push_back(mk(0,1,1,0,8'h56,4'h5,8'h40, 9'b000000000, 8'h00,8'h00,8'h00,8'h00,4'h0));
    vecs.push_back(mk(0,1,0,0,8'h00,4'h0,8'h40, 9'b111100000, 8'h40,8'h56,8'h3F,8'h00,4'h0));
    vecs.push_back(mk(0,1,0,0,8'h00,4'h0,8'h3F, 9'b111100000, 8'h3F,8'h05,8'h3E,8'h00,4'h0));
    vecs.push_back(mk(0,1,0,0,8'h00,4'h0,8'h3E, 9'b110001100, 8'h01,8'h00,8'h00,8'h00,4'h0));
    vecs.push_back(mk(0,0,0,0,8'h00,4'h0,8'h3E, 9'b000000000, 8'h00,8'h00,8'h00,8'h00,4'h0));
    // ext_rst_req in PUSH_FL: abort to RSTV, no INTV/ack
    vecs.push_back(mk(0,1,1,0,8'h77,4'h3,8'h80, 9'b000000000, 8'h00,8'h00,8'h00,8'h00,4'h0));
    vecs.push_back(mk(0,1,0,0,8'h00,4'h0,8'h80, 9'b111100000, 8'h80,8'h77,8'h7F,8'h00,4'h0));
    vecs.push_back(mk(1,1,0,0,8'h00,4'h0,8'h7F, 9'b111100000, 8'h7F,8'h03,8'h7E,8'h00,4'h0));
    vecs.push_back(mk(1,1,1,0,8'h00,4'h0,8'h7E, 9'b110010000, 8'h00,8'h00,8'h00,8'h00,4'h0));
    vecs.push_back(mk(0,1,1,0,8'h00,4'h0,8'h7E, 9'b110010000, 8'h00,8'h00,8'h00,8'h00,4'h0));
    vecs.push_back(mk(0,0,0,0,8'h00,4'h0,8'h7E, 9'b000000000, 8'h00,8'h00,8'h00,8'h00,4'h0));
    // Interrupt with SP=00: pushes to 00 then FF, SP ends FE
    vecs.push_back(mk(0,1,1,0,8'h12,4'hF,8'h00, 9'b000000000, 8'h00,8'h00,8'h00,8'h00,4'h0));
    vecs.push_back(mk(0,1,0,0,8'h00,4'h0,8'h00, 9'b111100000, 8'h00,8'h12,8'hFF,8'h00,4'h0));
    vecs.push_back(mk(0,1,0,0,8'h00,4'h0,8'hFF, 9'b111100000, 8'hFF,8'h0F,8'hFE,8'h00,4'h0));
    vecs.push_back(mk(0,1,0,0,8'h00,4'h0,8'hFE, 9'b110001100, 8'h01,8'h00,8'h00,8'h00,4'h0));
    vecs.push_back(mk(0,0,0,0,8'h00,4'h0,8'hFE, 9'b000000000, 8'h00,8'h00,8'h00,8'h00,4'h0));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("v%0d ctrl", i),       32'(ctrl_now()),      32'(vecs[i].ctrl));
      check($sformatf("v%0d mem_addr", i),   32'(bus.mem_addr),    32'(vecs[i].addr));
      check($sformatf("v%0d mem_wdata", i),  32'(bus.mem_wdata),   32'(vecs[i].wdata));
      check($sformatf("v%0d sp_wr_data", i), 32'(sp_wr_data),      32'(vecs[i].spd));
      check($sformatf("v%0d ret_addr", i),   32'(ret_addr),        32'(vecs[i].ret));
      check($sformatf("v%0d flags_rest", i), 32'(flags_rest),      32'(vecs[i].flr));
      @(posedge clk);
      #1;
    end

    check("mem[00]", 32'(mem[8'h00]), 32'h12);
    check("mem[01]", 32'(mem[8'h01]), 32'h80);
    check("mem[FF]", 32'(mem[8'hFF]), 32'h0F);
    check("mem[FE]", 32'(mem[8'hFE]), 32'h0A);
    check("mem[40]", 32'(mem[8'h40]), 32'h56);
    check("mem[3F]", 32'(mem[8'h3F]), 32'h05);
    check("mem[80]", 32'(mem[8'h80]), 32'h77);
    check("mem[7F]", 32'(mem[8'h7F]), 32'h03);

    // Interrupt latency: three stall cycles, ack in the last one
    intr_req = 1'b1; instr_boundary = 1'b1; pc_in = 8'h21; flags_in = 4'h6; sp_in = 8'h90;
    stall_cnt = 0; seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (intr_ack) seen = 1'b1;
      else begin
        @(posedge clk);
        #1 instr_boundary = 1'b0;
      end
    end
    check("intr ack seen", 32'(seen), 32'd1);
    check("intr stall cycles", 32'(stall_cnt), 32'd3);
    @(posedge clk);
    #1 intr_req = 1'b0;
    @(negedge clk);
    check("intr stall dropped", 32'(stall), 32'd0);
    check("intr push pc", 32'(mem[8'h90]), 32'h21);
    check("intr push fl", 32'(mem[8'h8F]), 32'h06);

    // RTI latency: two stall cycles, ret_valid in the last one
    @(posedge clk);
    #1 rti_req = 1'b1; sp_in = 8'h8E;
    @(posedge clk);
    #1 rti_req = 1'b0;
    stall_cnt = 0; seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (ret_valid) begin
        seen = 1'b1;
        check("rti ret_addr", 32'(ret_addr), 32'h21);
        check("rti sp_wr_data", 32'(sp_wr_data), 32'h90);
      end else begin
        if (flags_rest_en) check("rti flags_rest", 32'(flags_rest), 32'h6);
        @(posedge clk);
        #1;
      end
    end
    check("rti ret seen", 32'(seen), 32'd1);
    check("rti stall cycles", 32'(stall_cnt), 32'd2);

    // Asynchronous rst in the middle of PUSH_PC
    @(posedge clk);
    #1 intr_req = 1'b1; instr_boundary = 1'b1; pc_in = 8'h44; sp_in = 8'h50;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst ctrl", 32'(ctrl_now()), 32'(9'b110010000));
    check("async rst addr", 32'(bus.mem_addr), 32'h00);
    @(posedge clk);
    #1 rst = 1'b0; intr_req = 1'b0; instr_boundary = 1'b0;
    @(negedge clk);
    check("post rst RSTV", 32'(ctrl_now()), 32'(9'b110010000));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("post rst IDLE", 32'(ctrl_now()), 32'(9'b000000000));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
